ecc_secded_dec_pipe: RTL and testbench
======================================

// Module: ecc_secded_dec_pipe
// PURPOSE
//  Parametrised, pipelined SECDED (Hamming + overall parity) decoder on the packet-buffer read path.
//  Sits between page SRAM read data and the egress datapath, with valid/ready flow control.
//  Corrects single-bit errors and flags double-bit errors.
//  Keeps saturating corrected/uncorrectable counters for the CSR block.
// PARAMETERS
//  DATA_W  128  data bits per beat
//  CHK_W   9    check bits: CHK_W-1 Hamming bits + 1 overall parity; need 2^(CHK_W-1) >= DATA_W+CHK_W
//  CNT_W   16   width of each error counter
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        input beat valid
//  in_ready   out  1        decoder can accept a beat
//  in_data    in   DATA_W   raw data from SRAM
//  in_chk     in   CHK_W    stored check bits; [CHK_W-1] = overall parity
//  in_cor_en  in   1        1 = correct this beat; 0 = pass data through, still classify
//  out_valid  out  1        output beat valid
//  out_ready  in   1        downstream accepts
//  out_data   out  DATA_W   corrected data
//  out_sbe    out  1        single-bit error detected (corrected if in_cor_en)
//  out_dbe    out  1        uncorrectable error
//  out_syn    out  CHK_W-1  Hamming syndrome of this beat
//  cnt_clr    in   1        clear both counters
//  cnt_sbe    out  CNT_W    saturating count of accepted beats with out_sbe
//  cnt_dbe    out  CNT_W    saturating count of accepted beats with out_dbe
// BEHAVIOUR
//  - Codeword positions: 1..DATA_W+CHK_W-1. Hamming check bit i sits at position 2^i.
//  - Data bits fill the non-power-of-2 positions in ascending order: d0->3, d1->5, d2->6, d3->7, d4->9, d5->10, ...
//  - syn = XOR of in_chk[CHK_W-2:0] with check bits recomputed over in_data.
//  - par = XOR of all in_data and all in_chk bits; 1 = mismatch.
//  - Classification:
//      syn==0, par==0                  -> clean
//      syn==0, par==1                  -> sbe; parity bit error, data unchanged
//      syn!=0, par==1, syn<=max_pos    -> sbe; flip data bit at position syn if it is a data position
//                                         (check-bit position: data unchanged)
//      syn!=0, par==0                  -> dbe
//      syn>max_pos, par==1             -> dbe
//  - out_sbe and out_dbe are never both 1.
//  - If in_cor_en=0: out_data = in_data; flags and syn are still reported.
//  - Pipeline: 2 stages.
//      S1 registers data, syn, par, cor_en.
//      S2 registers corrected data and flags.
//  - Latency: 2 cycles from accept to out_valid when out_ready is held high. Throughput: 1 beat/clk.
//  - Global stall: adv = !out_valid | out_ready; in_ready = adv.
//      On a stall, both stages hold their contents; out_* stay stable while out_valid & !out_ready.
//  - A beat transfers in on in_valid & in_ready, and out on out_valid & out_ready.
//  - Counters increment on output transfer. They saturate at all-ones and do not wrap.
//      cnt_clr has priority over an increment in the same cycle; the counter reads 0 next cycle.
//  - Reset: out_valid=0, stage valids=0, out_data=0, out_sbe=0, out_dbe=0, out_syn=0, cnt_sbe=0, cnt_dbe=0.
//      in_ready=1 the cycle after reset.
//      Reset mid-stream drops in-flight beats; no partial output is produced.
// CONFIGURATION
//  ECC_ERR_INJ_EN defined:
//    - Adds ports inj_arm (in, 1) and inj_mask (in, DATA_W+CHK_W).
//    - inj_arm=1 latches inj_mask. The mask is XORed into {in_chk,in_data} of the next accepted beat only, then self-clears.
//    - inj_busy (out, 1) is high while a mask is pending.
//  ECC_ERR_INJ_EN undefined: no injection ports or logic; in_* reach S1 unmodified.
// TESTING
//  1. data=0, chk=0, cor_en=1 -> out_data=0 after 2 clk, sbe=0, dbe=0, syn=0.
//  2. Valid encoded word with d5 flipped -> out_data = original word, sbe=1, syn=8'h0A, cnt_sbe=1.
//  3. Same word with cor_en=0 -> out_data keeps d5 flipped, sbe=1, syn=8'h0A.
//  4. d0 and d1 flipped -> dbe=1, sbe=0, syn=8'h06, cnt_dbe increments.
//  5. Stream of 8 beats with out_ready low for 3 clk mid-stream -> no beat lost or duplicated; out_* held stable while stalled.
//  6. Force cnt_sbe to all-ones, then one more sbe beat -> stays all-ones.
//     cnt_clr together with an sbe transfer -> counter reads 0.
//     rst asserted mid-stream -> out_valid=0 next clk.

Source files
------------

// File: rtl/ecc_secded_dec_pipe.sv
// Pipelined SECDED (Hamming + overall parity) decoder with saturating SBE/DBE counters.
// Latency: 2 cycles from input accept to out_valid; throughput 1 beat/clk.
// Backpressure: a single stall signal (adv = !out_valid | out_ready) freezes both stages; in_ready = adv.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          input handshake; in_data, in_chk (MSB = overall parity), in_cor_en
//   out_valid/out_ready        output handshake; out_data, out_sbe, out_dbe, out_syn
//   cnt_clr, cnt_sbe, cnt_dbe  counter clear and saturating error counts (bump on output transfer)
// Optional: ECC_ERR_INJ_EN adds inj_arm, inj_mask, inj_busy. The latched mask is XORed
//   into {in_chk, in_data} of the next accepted beat only.
module ecc_secded_dec_pipe #(
    parameter int DATA_W = 128,
    parameter int CHK_W  = 9,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [CHK_W-1:0]        in_chk,
    input  logic                    in_cor_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_sbe,
    output logic                    out_dbe,
    output logic [CHK_W-2:0]        out_syn,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        cnt_sbe,
    output logic [CNT_W-1:0]        cnt_dbe
`ifdef ECC_ERR_INJ_EN
    ,
    input  logic                    inj_arm,
    input  logic [DATA_W+CHK_W-1:0] inj_mask,
    output logic                    inj_busy
`endif
);

    localparam int HAM_W   = CHK_W - 1;
    localparam int MAX_POS = DATA_W + CHK_W - 1;

    // Codeword position of data bit k: step over each power-of-two slot at or below it.
    function automatic int data_pos(input int k);
        int p;
        p = k + 1;
        for (int i = 0; i < HAM_W; i++) begin
            if ((1 << i) <= p) p = p + 1;
        end
        return p;
    endfunction

    logic                    w_adv;
    logic                    w_accept;
    logic [DATA_W+CHK_W-1:0] w_in_cw;
    logic [DATA_W-1:0]       w_in_data;
    logic [CHK_W-1:0]        w_in_chk;
    logic [HAM_W-1:0]        w_recalc;

    logic                    r_s1_vld;
    logic [DATA_W-1:0]       r_s1_data;
    logic [HAM_W-1:0]        r_s1_syn;
    logic                    r_s1_par;
    logic                    r_s1_cor_en;

    logic                    w_syn_nz;
    logic                    w_in_range;
    logic                    w_sbe;
    logic                    w_dbe;
    logic [DATA_W-1:0]       w_cor_data;

    logic                    r_out_vld;
    logic [DATA_W-1:0]       r_out_data;
    logic                    r_out_sbe;
    logic                    r_out_dbe;
    logic [HAM_W-1:0]        r_out_syn;
    logic [CNT_W-1:0]        r_cnt_sbe;
    logic [CNT_W-1:0]        r_cnt_dbe;
    logic                    w_out_xfer;

    assign w_adv    = !r_out_vld || out_ready;
    assign w_accept = in_valid && w_adv;

`ifdef ECC_ERR_INJ_EN
    logic                    r_inj_busy;
    logic [DATA_W+CHK_W-1:0] r_inj_mask;

    // A new arm wins over the clear, so arming during an accept queues the new mask
    // for the following beat while the old one is consumed now.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inj_busy <= 1'b0;
            r_inj_mask <= '0;
        end else if (inj_arm) begin
            r_inj_busy <= 1'b1;
            r_inj_mask <= inj_mask;
        end else if (w_accept) begin
            r_inj_busy <= 1'b0;
        end
    end

    assign inj_busy = r_inj_busy;
    assign w_in_cw  = {in_chk, in_data} ^ (r_inj_busy ? r_inj_mask : '0);
`else
    assign w_in_cw  = {in_chk, in_data};
`endif

    assign w_in_data = w_in_cw[DATA_W-1:0];
    assign w_in_chk  = w_in_cw[DATA_W+CHK_W-1:DATA_W];

    // Check bit i covers every data bit whose codeword position has bit i set.
    always_comb begin
        w_recalc = '0;
        for (int i = 0; i < HAM_W; i++) begin
            for (int k = 0; k < DATA_W; k++) begin
                if (((data_pos(k) >> i) & 1) != 0) w_recalc[i] = w_recalc[i] ^ w_in_data[k];
            end
        end
    end

    // Stage 2 classification. A syndrome of 0 with parity mismatch is a parity-bit error.
    assign w_syn_nz   = |r_s1_syn;
    assign w_in_range = (int'(r_s1_syn) <= MAX_POS);
    assign w_sbe      = r_s1_par && w_in_range;
    assign w_dbe      = w_syn_nz && (!r_s1_par || !w_in_range);

    // Only data positions are flipped; a check-bit position leaves data untouched.
    always_comb begin
        w_cor_data = r_s1_data;
        if (w_sbe && r_s1_cor_en) begin
            for (int k = 0; k < DATA_W; k++) begin
                if (int'(r_s1_syn) == data_pos(k)) w_cor_data[k] = ~r_s1_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld    <= 1'b0;
            r_s1_data   <= '0;
            r_s1_syn    <= '0;
            r_s1_par    <= 1'b0;
            r_s1_cor_en <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_data  <= '0;
            r_out_sbe   <= 1'b0;
            r_out_dbe   <= 1'b0;
            r_out_syn   <= '0;
        end else if (w_adv) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_data   <= w_in_data;
                r_s1_syn    <= w_in_chk[HAM_W-1:0] ^ w_recalc;
                r_s1_par    <= ^w_in_cw;
                r_s1_cor_en <= in_cor_en;
            end
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_data <= w_cor_data;
                r_out_sbe  <= w_sbe;
                r_out_dbe  <= w_dbe;
                r_out_syn  <= r_s1_syn;
            end
        end
    end

    assign w_out_xfer = r_out_vld && out_ready;

    // Clear beats a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt_sbe <= '0;
            r_cnt_dbe <= '0;
        end else if (w_out_xfer) begin
            if (r_out_sbe && !(&r_cnt_sbe)) r_cnt_sbe <= r_cnt_sbe + CNT_W'(1);
            if (r_out_dbe && !(&r_cnt_dbe)) r_cnt_dbe <= r_cnt_dbe + CNT_W'(1);
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_out_vld;
    assign out_data  = r_out_data;
    assign out_sbe   = r_out_sbe;
    assign out_dbe   = r_out_dbe;
    assign out_syn   = r_out_syn;
    assign cnt_sbe   = r_cnt_sbe;
    assign cnt_dbe   = r_cnt_dbe;

endmodule

// File: tb/tb_ecc_secded_dec_pipe.sv
module tb_ecc_secded_dec_pipe;

    localparam int DW   = 128;
    localparam int CW   = 9;
    localparam int HW   = CW - 1;
    localparam int CNTW = 4;
    localparam int MAXP = DW + CW - 1;
    localparam int NB   = DW + CW;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [CW-1:0]   in_chk;
    logic            in_cor_en;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_sbe;
    logic            out_dbe;
    logic [HW-1:0]   out_syn;
    logic            cnt_clr;
    logic [CNTW-1:0] cnt_sbe;
    logic [CNTW-1:0] cnt_dbe;

    ecc_secded_dec_pipe #(.DATA_W(DW), .CHK_W(CW), .CNT_W(CNTW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chk(in_chk),
        .in_cor_en(in_cor_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sbe(out_sbe), .out_dbe(out_dbe), .out_syn(out_syn),
        .cnt_clr(cnt_clr), .cnt_sbe(cnt_sbe), .cnt_dbe(cnt_dbe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dpos[DW];      // codeword position of each data bit
    int exp_cs = 0;    // model of cnt_sbe
    int exp_cd = 0;    // model of cnt_dbe

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          cor;
        logic [DW-1:0] xd;
        logic          xs;
        logic          xdbe;
        logic [HW-1:0] xsyn;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
        logic [HW-1:0] syn;
    } exp_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        int s;
        logic [HW-1:0] h;
        s = 0;
        for (int k = 0; k < DW; k++) if (d[k]) s = s ^ dpos[k];
        h = s[HW-1:0];
        return {(^d) ^ (^h), h};
    endfunction

    // Syndrome = XOR of the positions of all set Hamming-codeword bits.
    task automatic ref_dec(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic cor,
                           output exp_t r);
        int s;
        logic par;
        s = 0;
        for (int i = 0; i < HW; i++) if (c[i]) s = s ^ (1 << i);
        for (int k = 0; k < DW; k++) if (d[k]) s = s ^ dpos[k];
        par = (^d) ^ (^c);
        r.d = d; r.s = 1'b0; r.e = 1'b0; r.syn = s[HW-1:0];
        if (s == 0 && !par) begin
        end else if (par && s <= MAXP) begin
            r.s = 1'b1;
            if (cor && s != 0)
                for (int k = 0; k < DW; k++) if (dpos[k] == s) r.d[k] = ~r.d[k];
        end else begin
            r.e = 1'b1;
        end
    endtask

    task automatic rand_beat(input int mode, output logic [DW-1:0] d, output logic [CW-1:0] c,
                             output logic cor);
        logic [NB-1:0] flat;
        int nf;
        d = {$urandom, $urandom, $urandom, $urandom};
        flat = {encode(d), d};
        nf = (mode == 2) ? 1 : int'($urandom_range(0, 3));
        for (int i = 0; i < nf; i++) begin
            int idx;
            idx = (mode == 2) ? int'($urandom_range(0, DW - 1)) : int'($urandom_range(0, NB - 1));
            flat[idx] = ~flat[idx];
        end
        d = flat[DW-1:0];
        c = flat[NB-1:DW];
        cor = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    endtask

    // mode 0: steady input with out_ready low for 3 clk; 1: random valid/ready; 2: sbe-only, ready high
    task automatic run_stream(input int nbeats, input int mode);
        exp_t q[$];
        exp_t r;
        exp_t held;
        int sent, got, cyc;
        logic prev_stall;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic cor;
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0;
        held = '{d: '0, s: 1'b0, e: 1'b0, syn: '0};
        while (got < nbeats && cyc < 4000) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_hold_vld", {127'b0, out_valid}, 1);
                chk("stall_hold_data", out_data, held.d);
                chk("stall_hold_flags", {out_sbe, out_dbe, out_syn}, {held.s, held.e, held.syn});
            end
            if (mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = (sent < nbeats) && ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = !(mode == 0 && cyc >= 4 && cyc < 7);
                in_valid  = (sent < nbeats);
            end
            rand_beat(mode, d, c, cor);
            in_data = d; in_chk = c; in_cor_en = cor;
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    r = q.pop_front();
                    chk("stream_data", out_data, r.d);
                    chk("stream_flags", {out_sbe, out_dbe, out_syn}, {r.s, r.e, r.syn});
                    if (r.s && exp_cs < CMAX) exp_cs++;
                    if (r.e && exp_cd < CMAX) exp_cd++;
                end
                got++;
            end
            if (in_valid && in_ready) begin
                ref_dec(d, c, cor, r);
                q.push_back(r);
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            held = '{d: out_data, s: out_sbe, e: out_dbe, syn: out_syn};
            cyc++;
        end
        if (got < nbeats) chk("stream_timeout_beats", got, nbeats);
        chk("stream_leftover", q.size(), 0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    vec_t tbl[9];

    initial begin
        logic [DW-1:0] w, one;
        logic [CW-1:0] cw;
        logic [CW-1:0] cone;
        int p;
        p = 1;
        for (int k = 0; k < DW; k++) begin
            while ((p & (p - 1)) == 0) p++;
            dpos[k] = p;
            p++;
        end

        w    = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        cw   = encode(w);
        one  = 1;
        cone = 1;
        tbl[0] = '{d: '0, c: '0, cor: 1'b1, xd: '0, xs: 1'b0, xdbe: 1'b0, xsyn: 8'h00};
        tbl[1] = '{d: w ^ (one << 5), c: cw, cor: 1'b1, xd: w, xs: 1'b1, xdbe: 1'b0, xsyn: 8'h0A};
        tbl[2] = '{d: w ^ (one << 5), c: cw, cor: 1'b0, xd: w ^ (one << 5), xs: 1'b1, xdbe: 1'b0, xsyn: 8'h0A};
        tbl[3] = '{d: w ^ 128'h3, c: cw, cor: 1'b1, xd: w ^ 128'h3, xs: 1'b0, xdbe: 1'b1, xsyn: 8'h06};
        tbl[4] = '{d: w, c: cw ^ (cone << 8), cor: 1'b1, xd: w, xs: 1'b1, xdbe: 1'b0, xsyn: 8'h00};
        tbl[5] = '{d: w, c: cw ^ cone, cor: 1'b1, xd: w, xs: 1'b1, xdbe: 1'b0, xsyn: 8'h01};
        tbl[6] = '{d: w ^ (one << 127), c: cw, cor: 1'b1, xd: w, xs: 1'b1, xdbe: 1'b0, xsyn: 8'h88};
        // d0, d7, d122 sit at positions 3, 12, 131: odd weight but syndrome 140 > 136
        tbl[7] = '{d: w ^ (one << 0) ^ (one << 7) ^ (one << 122), c: cw, cor: 1'b1,
                   xd: w ^ (one << 0) ^ (one << 7) ^ (one << 122), xs: 1'b0, xdbe: 1'b1, xsyn: 8'h8C};
        tbl[8] = '{d: w, c: cw, cor: 1'b1, xd: w, xs: 1'b0, xdbe: 1'b0, xsyn: 8'h00};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_chk = '0; in_cor_en = 1'b1;
        out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {127'b0, out_valid}, 0);
        chk("rst_in_ready", {127'b0, in_ready}, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {out_sbe, out_dbe, out_syn}, 0);
        chk("rst_counters", {cnt_sbe, cnt_dbe}, 0);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = tbl[i].d; in_chk = tbl[i].c; in_cor_en = tbl[i].cor;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_lat1_valid", i), {127'b0, out_valid}, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), {127'b0, out_valid}, 1);
            chk($sformatf("vec%0d_data", i), out_data, tbl[i].xd);
            chk($sformatf("vec%0d_flags", i), {out_sbe, out_dbe, out_syn},
                {tbl[i].xs, tbl[i].xdbe, tbl[i].xsyn});
            if (tbl[i].xs) exp_cs++;
            if (tbl[i].xdbe) exp_cd++;
            @(negedge clk);
            chk($sformatf("vec%0d_cnt", i), {cnt_sbe, cnt_dbe}, {exp_cs[CNTW-1:0], exp_cd[CNTW-1:0]});
        end

        run_stream(8, 0);
        chk("stall_cnt", {cnt_sbe, cnt_dbe}, {exp_cs[CNTW-1:0], exp_cd[CNTW-1:0]});
        run_stream(300, 1);
        chk("rand_cnt", {cnt_sbe, cnt_dbe}, {exp_cs[CNTW-1:0], exp_cd[CNTW-1:0]});

        // saturation
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0; exp_cs = 0; exp_cd = 0;
        chk("clr_cnt", {cnt_sbe, cnt_dbe}, 0);
        run_stream(CMAX, 2);
        chk("sat_reach", cnt_sbe, CMAX);
        run_stream(1, 2);
        chk("sat_hold", cnt_sbe, CMAX);

        // clear wins over a same-cycle sbe transfer
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0; exp_cs = 0; exp_cd = 0;
        run_stream(2, 2);
        chk("pre_clr_cnt", cnt_sbe, 2);
        in_valid = 1'b1; in_data = tbl[1].d; in_chk = tbl[1].c; in_cor_en = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("clr_xfer_valid", {out_valid, out_sbe}, 2'b11);
        cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        chk("clr_priority", cnt_sbe, 0);

        // reset mid-stream drops in-flight beats
        in_valid = 1'b1; in_data = tbl[1].d; in_chk = tbl[1].c;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", {127'b0, out_valid}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {127'b0, out_valid}, 0);
        chk("mid_rst_ready", {127'b0, in_ready}, 1);
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_out", {127'b0, out_valid}, 0);
        end
        chk("post_rst_data", out_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
